// File: rtl/fp_norm_pkg.sv
// Shared constants and FSM state type for the post-add normaliser.
package fp_norm_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 23;

  // All-ones exponent (infinity) and exponent bias for the default widths.
  localparam logic [EXP_W_DEF-1:0] EXP_MAX = {EXP_W_DEF{1'b1}};
  localparam logic [EXP_W_DEF-1:0] BIAS    = EXP_W_DEF'((1 << (EXP_W_DEF - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter. The count is taken from the MSB
// downwards; an all-zero input returns W.
module norm_lzc #(
  parameter int W     = 24,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] count_o
);

  logic found;

  // Priority scan: the first set bit from the top fixes the count.
  always_comb begin
    count_o = CNT_W'(W);
    found   = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = CNT_W'(W - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_normalizer.sv
// Post-add normalisation stage: takes the raw sum mantissa (carry + hidden +
// fraction) and the larger operand's exponent and returns a normalised
// fraction/exponent with overflow, underflow (flush-to-zero) and zero flags.
// Build option NORM_LZC_EN: when defined, the left-normalising shift is done
// in a single cycle from a leading-zero count; otherwise one bit per cycle.
// Results are identical in both builds, only latency differs.
module exp_normalizer
  import fp_norm_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [MANT_W+1:0] sum_mant_i,
  input  logic [EXP_W-1:0]  sum_exp_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MANT_W-1:0] norm_mant_o,
  output logic [EXP_W-1:0]  norm_exp_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              zero_o
);

  localparam logic [EXP_W-1:0] EXP_ALL = {EXP_W{1'b1}};

  norm_state_e       state_q, state_d;
  logic [MANT_W+1:0] w_mant_q, w_mant_d;
  logic [EXP_W-1:0]  w_exp_q, w_exp_d;
  logic              out_valid_q, out_valid_d;
  logic [MANT_W-1:0] norm_mant_q, norm_mant_d;
  logic [EXP_W-1:0]  norm_exp_q, norm_exp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              zero_q, zero_d;

  logic [EXP_W-1:0]  exp_inc;
  logic [MANT_W-1:0] res_mant;
  logic [EXP_W-1:0]  res_exp;
  logic              res_ovf, res_unf, res_zero, res_done;

  assign exp_inc = w_exp_q + EXP_W'(1);

`ifdef NORM_LZC_EN
  localparam int LZC_W = $clog2(MANT_W + 2);

  logic [LZC_W-1:0]  lzc;
  logic [MANT_W-1:0] mant_lsh;
  logic              lzc_ge_exp;

  norm_lzc #(
    .W     (MANT_W + 1),
    .CNT_W (LZC_W)
  ) u_lzc (
    .data_i  (w_mant_q[MANT_W:0]),
    .count_o (lzc)
  );

  // Fraction bits after the full left shift; the hidden bit lands above them.
  assign mant_lsh   = MANT_W'(w_mant_q << lzc);
  assign lzc_ge_exp = ({{EXP_W{1'b0}}, lzc} >= {{LZC_W{1'b0}}, w_exp_q});
`endif

  // State, working registers and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      w_mant_q    <= '0;
      w_exp_q     <= '0;
      out_valid_q <= 1'b0;
      norm_mant_q <= '0;
      norm_exp_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_mant_q    <= w_mant_d;
      w_exp_q     <= w_exp_d;
      out_valid_q <= out_valid_d;
      norm_mant_q <= norm_mant_d;
      norm_exp_q  <= norm_exp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  // One normalisation decision per NORM cycle, in priority order; a terminal
  // decision loads the result registers and moves to DONE.
  always_comb begin
    state_d     = state_q;
    w_mant_d    = w_mant_q;
    w_exp_d     = w_exp_q;
    out_valid_d = out_valid_q;
    norm_mant_d = norm_mant_q;
    norm_exp_d  = norm_exp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;
    res_mant    = '0;
    res_exp     = '0;
    res_ovf     = 1'b0;
    res_unf     = 1'b0;
    res_zero    = 1'b0;
    res_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          w_mant_d = sum_mant_i;
          w_exp_d  = sum_exp_i;
          state_d  = NORM;
        end
      end

      NORM: begin
        res_done = 1'b1;
        if (w_mant_q == '0) begin
          res_zero = 1'b1;
        end else if (w_exp_q == EXP_ALL) begin
          res_ovf = 1'b1;
          res_exp = EXP_ALL;
        end else if (w_exp_q == '0) begin
          res_unf = 1'b1;
        end else if (w_mant_q[MANT_W+1]) begin
          // Carry out of the add: one right shift always suffices.
          if (exp_inc == EXP_ALL) begin
            res_ovf = 1'b1;
            res_exp = EXP_ALL;
          end else begin
            res_mant = w_mant_q[MANT_W:1];
            res_exp  = exp_inc;
          end
        end else if (w_mant_q[MANT_W]) begin
          res_mant = w_mant_q[MANT_W-1:0];
          res_exp  = w_exp_q;
`ifdef NORM_LZC_EN
        end else if (lzc_ge_exp) begin
          // Exponent would reach 0 before the hidden bit is restored.
          res_unf = 1'b1;
        end else begin
          res_mant = mant_lsh;
          res_exp  = w_exp_q - EXP_W'(lzc);
        end
`else
        end else if (w_exp_q == EXP_W'(1)) begin
          res_unf = 1'b1;
        end else begin
          res_done = 1'b0;
          w_mant_d = w_mant_q << 1;
          w_exp_d  = w_exp_q - EXP_W'(1);
        end
`endif
        if (res_done) begin
          state_d     = DONE;
          norm_mant_d = res_mant;
          norm_exp_d  = res_exp;
          overflow_d  = res_ovf;
          underflow_d = res_unf;
          zero_d      = res_zero;
        end
      end

      DONE: begin
        // Result registers settle on entry; valid rises the following edge
        // and then holds until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign norm_mant_o = norm_mant_q;
  assign norm_exp_o  = norm_exp_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign zero_o      = zero_q;

endmodule
